// File: rtl/moment_accum_if.sv
// Sample/result handshake bus for moment_accum.
// master: sample producer and result consumer; slave: the accumulator.
interface moment_accum_if #(
  parameter int unsigned XW  = 8,
  parameter int unsigned YW  = 16,
  parameter int unsigned DEG = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned CW  = 10
);
  logic                      start;
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic [XW-1:0]             x;
  logic [YW-1:0]             y;
  logic                      out_valid;
  logic                      out_ready;
  logic [(2*DEG+1)*AW-1:0]   sx;
  logic [(DEG+1)*AW-1:0]     sxy;
  logic [CW-1:0]             count;
  logic                      ovf;

  modport master (
    output start, in_valid, in_last, x, y, out_ready,
    input  in_ready, out_valid, sx, sxy, count, ovf
  );

  modport slave (
    input  start, in_valid, in_last, x, y, out_ready,
    output in_ready, out_valid, sx, sxy, count, ovf
  );
endinterface

// File: rtl/moment_accum.sv
// Streaming power-sum accumulator: Sx[k]=sum x^k (k<=2*DEG), Sxy[k]=sum y*x^k (k<=DEG).
// Optional macro MOMENT_SAT_EN: accumulators and count saturate instead of wrapping.
module moment_accum #(
  parameter int unsigned XW  = 8,
  parameter int unsigned YW  = 16,
  parameter int unsigned DEG = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned CW  = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  moment_accum_if.slave  bus
);

  localparam int unsigned NS  = 2*DEG + 1;
  localparam int unsigned NY  = DEG + 1;
  localparam int unsigned DCW = $clog2(NS + 1);
  // Last sample reaches the top stage after 2*DEG edges and is summed one edge later.
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(NS);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [DCW-1:0]  drain_q;

  logic            vld_q [NS];
  logic [XW-1:0]   x_q   [NS-1];
  logic [YW-1:0]   y_q   [NY];
  logic [AW-1:0]   p_q   [NS];
  logic [AW-1:0]   p_d   [NS];

  logic [AW-1:0]   sx_q  [NS];
  logic [AW-1:0]   sx_d  [NS];
  logic [AW-1:0]   sxy_q [NY];
  logic [AW-1:0]   sxy_d [NY];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic accept;
  logic frame_start;

  assign accept      = bus.in_valid & in_ready_q;
  assign frame_start = (state_q == IDLE) & bus.start;

  function automatic logic [AW:0] acc_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef MOMENT_SAT_EN
    if (s[AW]) s[AW-1:0] = '1;
`endif
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      drain_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_q    <= ACCUM;
          in_ready_q <= 1'b1;
        end
        ACCUM: if (accept && bus.in_last) begin
          state_q    <= DRAIN;
          in_ready_q <= 1'b0;
          drain_q    <= DRAIN_LOAD;
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        DONE: if (bus.out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    logic [AW+XW-1:0] prod;
    prod   = '0;
    p_d[0] = AW'(1);
    for (int unsigned k = 1; k < NS; k++) begin
      prod   = (AW+XW)'(p_q[k-1]) * (AW+XW)'(x_q[k-1]);
      p_d[k] = prod[AW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NS; k++) begin
        vld_q[k] <= 1'b0;
        p_q[k]   <= '0;
      end
      for (int unsigned k = 0; k < NS-1; k++) x_q[k] <= '0;
      for (int unsigned k = 0; k < NY; k++)   y_q[k] <= '0;
    end else begin
      vld_q[0] <= accept;
      x_q[0]   <= bus.x;
      y_q[0]   <= bus.y;
      p_q[0]   <= p_d[0];
      for (int unsigned k = 1; k < NS; k++) begin
        vld_q[k] <= vld_q[k-1];
        p_q[k]   <= p_d[k];
      end
      for (int unsigned k = 1; k < NS-1; k++) x_q[k] <= x_q[k-1];
      for (int unsigned k = 1; k < NY; k++)   y_q[k] <= y_q[k-1];
    end
  end

  always_comb begin
    logic [AW:0]      sum;
    logic [AW+YW-1:0] yp;
    logic [CW:0]      csum;
    sx_d  = sx_q;
    sxy_d = sxy_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    sum   = '0;
    yp    = '0;
    csum  = '0;
    if (frame_start) begin
      for (int unsigned k = 0; k < NS; k++) sx_d[k]  = '0;
      for (int unsigned k = 0; k < NY; k++) sxy_d[k] = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (vld_q[0]) begin
        csum = {1'b0, cnt_q} + (CW+1)'(1);
`ifdef MOMENT_SAT_EN
        cnt_d = csum[CW] ? '1 : csum[CW-1:0];
`else
        cnt_d = csum[CW-1:0];
`endif
        ovf_d = ovf_d | csum[CW];
      end
      for (int unsigned k = 0; k < NS; k++) begin
        if (vld_q[k]) begin
          sum     = acc_add(sx_q[k], p_q[k]);
          sx_d[k] = sum[AW-1:0];
          ovf_d   = ovf_d | sum[AW];
        end
      end
      for (int unsigned k = 0; k < NY; k++) begin
        if (vld_q[k]) begin
          yp       = (AW+YW)'(y_q[k]) * (AW+YW)'(p_q[k]);
          sum      = acc_add(sxy_q[k], yp[AW-1:0]);
          sxy_d[k] = sum[AW-1:0];
          ovf_d    = ovf_d | sum[AW];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NS; k++) sx_q[k]  <= '0;
      for (int unsigned k = 0; k < NY; k++) sxy_q[k] <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sx_q  <= sx_d;
      sxy_q <= sxy_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.count     = cnt_q;
  assign bus.ovf       = ovf_q;

  for (genvar g = 0; g < NS; g++) begin : g_sx
    assign bus.sx[g*AW +: AW] = sx_q[g];
  end
  for (genvar g = 0; g < NY; g++) begin : g_sxy
    assign bus.sxy[g*AW +: AW] = sxy_q[g];
  end

endmodule

// File: tb/tb_moment_accum.sv
// Bench for moment_accum: DEG=2/AW=32 and DEG=1/AW=16 instances against a whole-frame sum model.
module tb_moment_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef MOMENT_SAT_EN
  localparam bit SAT = 1'b1;
  localparam logic [15:0] EXP1_SX2 = 16'd65535;
`else
  localparam bit SAT = 1'b0;
  localparam logic [15:0] EXP1_SX2 = 16'd64514;
`endif

  moment_accum_if #(.XW(8), .YW(16), .DEG(2), .AW(32), .CW(10)) if2 ();
  moment_accum_if #(.XW(8), .YW(16), .DEG(1), .AW(16), .CW(10)) if1 ();

  moment_accum #(.XW(8), .YW(16), .DEG(2), .AW(32), .CW(10)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
  );
  moment_accum #(.XW(8), .YW(16), .DEG(1), .AW(16), .CW(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [7:0]   fx   [8];
  logic [15:0]  fy   [8];
  int unsigned  fgap [8];
  int unsigned  fn;

  logic [255:0] e_sx  [2];
  logic [255:0] e_sxy [2];
  logic [15:0]  e_cnt [2];
  logic         e_ovf [2];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no response within bound, required a response", name);
  endtask

  // Whole-frame model: plain sums of powers, then wrap or clamp once at the end.
  task automatic model(input int unsigned sel, input int unsigned deg, input int unsigned aw);
    logic [127:0] mask, cmask, tot, pk, v;
    mask = (128'd1 << aw) - 128'd1;
    cmask = (128'd1 << 10) - 128'd1;
    e_sx[sel] = '0;
    e_sxy[sel] = '0;
    e_ovf[sel] = 1'b0;
    for (int unsigned k = 0; k <= 2*deg; k++) begin
      tot = '0;
      for (int unsigned i = 0; i < fn; i++) begin
        pk = 128'd1;
        for (int unsigned j = 0; j < k; j++) pk = (pk * 128'(fx[i])) & mask;
        tot = tot + pk;
      end
      if (tot > mask) e_ovf[sel] = 1'b1;
      v = SAT ? ((tot > mask) ? mask : tot) : (tot & mask);
      e_sx[sel] = e_sx[sel] | (256'(v) << (k*aw));
    end
    for (int unsigned k = 0; k <= deg; k++) begin
      tot = '0;
      for (int unsigned i = 0; i < fn; i++) begin
        pk = 128'd1;
        for (int unsigned j = 0; j < k; j++) pk = (pk * 128'(fx[i])) & mask;
        tot = tot + ((128'(fy[i]) * pk) & mask);
      end
      if (tot > mask) e_ovf[sel] = 1'b1;
      v = SAT ? ((tot > mask) ? mask : tot) : (tot & mask);
      e_sxy[sel] = e_sxy[sel] | (256'(v) << (k*aw));
    end
    tot = 128'(fn);
    if (tot > cmask) e_ovf[sel] = 1'b1;
    v = SAT ? ((tot > cmask) ? cmask : tot) : (tot & cmask);
    e_cnt[sel] = v[15:0];
  endtask

  // Compare process: whenever results are presented they must equal the model.
  always @(negedge clk) begin
    if (rst_n && if2.out_valid) begin
      chk("d2_sx",    256'(if2.sx),    e_sx[0]);
      chk("d2_sxy",   256'(if2.sxy),   e_sxy[0]);
      chk("d2_count", 256'(if2.count), 256'(e_cnt[0]));
      chk("d2_ovf",   256'(if2.ovf),   256'(e_ovf[0]));
      chk("d2_ready_in_done", 256'(if2.in_ready), 256'(0));
    end
    if (rst_n && if1.out_valid) begin
      chk("d1_sx",    256'(if1.sx),    e_sx[1]);
      chk("d1_sxy",   256'(if1.sxy),   e_sxy[1]);
      chk("d1_count", 256'(if1.count), 256'(e_cnt[1]));
      chk("d1_ovf",   256'(if1.ovf),   256'(e_ovf[1]));
    end
  end

  task automatic drive(input bit sel, input logic v, input logic [7:0] xv,
                       input logic [15:0] yv, input logic lst);
    if (sel) begin
      if1.in_valid = v; if1.x = xv; if1.y = yv; if1.in_last = lst;
    end else begin
      if2.in_valid = v; if2.x = xv; if2.y = yv; if2.in_last = lst;
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) if1.start = v; else if2.start = v;
  endtask

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic send(input bit sel, input logic [7:0] xv, input logic [15:0] yv,
                      input logic lst, output longint unsigned acc_t);
    int unsigned n = 0;
    drive(sel, 1'b1, xv, yv, lst);
    while (!(sel ? if1.in_ready : if2.in_ready) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n == 20) timeout("in_ready_wait");
    @(posedge clk);
    acc_t = $time;
    #1;
    drive(sel, 1'b0, 8'd0, 16'd0, 1'b0);
  endtask

  task automatic run_frame(input bit sel, input int unsigned lat_req);
    longint unsigned last_t = 0;
    longint unsigned lat;
    int unsigned n = 0;
    if (sel) model(1, 1, 16); else model(0, 2, 32);
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    for (int unsigned i = 0; i < fn; i++) begin
      repeat (fgap[i]) begin @(posedge clk); #1; end
      send(sel, fx[i], fy[i], (i == fn-1), last_t);
    end
    while (!(sel ? if1.out_valid : if2.out_valid) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n == 50) timeout("out_valid_wait");
    lat = ($time - 1 - last_t) / 10;
    chk(sel ? "d1_latency" : "d2_latency", 256'(lat), 256'(lat_req));
  endtask

  task automatic release2();
    if2.out_ready = 1'b1;
    @(posedge clk); #1;
    if2.out_ready = 1'b0;
    chk("d2_idle_out_valid", 256'(if2.out_valid), 256'(0));
    chk("d2_idle_in_ready",  256'(if2.in_ready),  256'(0));
  endtask

  task automatic set_frame(input int unsigned n);
    fn = n;
    for (int unsigned i = 0; i < 8; i++) begin
      fx[i] = 8'd0; fy[i] = 16'd0; fgap[i] = 0;
    end
  endtask

  initial begin
    longint unsigned t_dummy;
    if2.start = 1'b0; if2.out_ready = 1'b0;
    if1.start = 1'b0; if1.out_ready = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 16'd0, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 16'd0, 1'b0);
    for (int unsigned s = 0; s < 2; s++) begin
      e_sx[s] = '0; e_sxy[s] = '0; e_cnt[s] = '0; e_ovf[s] = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 256'(if2.out_valid), 256'(0));
    chk("rst_in_ready",  256'(if2.in_ready),  256'(0));
    chk("rst_sx",        256'(if2.sx),        256'(0));
    chk("rst_sxy",       256'(if2.sxy),       256'(0));
    chk("rst_count",     256'(if2.count),     256'(0));
    chk("rst_ovf",       256'(if2.ovf),       256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 1: x={1,2,3}, y=1, back to back.
    set_frame(3);
    fx[0] = 8'd1; fx[1] = 8'd2; fx[2] = 8'd3;
    fy[0] = 16'd1; fy[1] = 16'd1; fy[2] = 16'd1;
    run_frame(1'b0, 6);
    chk("f1_sx",  256'(if2.sx),  256'({32'd98, 32'd36, 32'd14, 32'd6, 32'd3}));
    chk("f1_sxy", 256'(if2.sxy), 256'({32'd14, 32'd6, 32'd3}));
    chk("f1_count", 256'(if2.count), 256'(3));
    chk("f1_ovf",   256'(if2.ovf),   256'(0));

    // Hold results with out_ready low while start is (ignored) high.
    if2.start = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 256'(if2.out_valid), 256'(1));
      chk("hold_in_ready",  256'(if2.in_ready),  256'(0));
    end
    if2.start = 1'b0;
    release2();
    @(posedge clk); #1;
    chk("idle_needs_start", 256'(if2.in_ready), 256'(0));

    // Frame 2: y={2,0,1} with two bubbles before samples 2 and 3.
    set_frame(3);
    fx[0] = 8'd1; fx[1] = 8'd2; fx[2] = 8'd3;
    fy[0] = 16'd2; fy[1] = 16'd0; fy[2] = 16'd1;
    fgap[1] = 2; fgap[2] = 2;
    run_frame(1'b0, 6);
    chk("f2_sxy", 256'(if2.sxy), 256'({32'd11, 32'd5, 32'd3}));
    chk("f2_sx",  256'(if2.sx),  256'({32'd98, 32'd36, 32'd14, 32'd6, 32'd3}));
    release2();

    // Frame 3: single sample.
    set_frame(1);
    fx[0] = 8'd4; fy[0] = 16'd3;
    run_frame(1'b0, 6);
    chk("f3_sx",  256'(if2.sx),  256'({32'd256, 32'd64, 32'd16, 32'd4, 32'd1}));
    chk("f3_sxy", 256'(if2.sxy), 256'({32'd48, 32'd12, 32'd3}));
    chk("f3_count", 256'(if2.count), 256'(1));
    release2();

    // Frame 4: aborted by reset after two samples.
    if2.start = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0;
    send(1'b0, 8'd5, 16'd7, 1'b0, t_dummy);
    send(1'b0, 8'd6, 16'd9, 1'b0, t_dummy);
    rst_n = 1'b0;
    #1;
    chk("abort_sx",        256'(if2.sx),        256'(0));
    chk("abort_sxy",       256'(if2.sxy),       256'(0));
    chk("abort_count",     256'(if2.count),     256'(0));
    chk("abort_in_ready",  256'(if2.in_ready),  256'(0));
    chk("abort_out_valid", 256'(if2.out_valid), 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame 5: fresh frame after the abort.
    set_frame(1);
    fx[0] = 8'd1; fy[0] = 16'd1;
    run_frame(1'b0, 6);
    chk("f5_sx",  256'(if2.sx),  256'({32'd1, 32'd1, 32'd1, 32'd1, 32'd1}));
    chk("f5_sxy", 256'(if2.sxy), 256'({32'd1, 32'd1, 32'd1}));
    chk("f5_ovf", 256'(if2.ovf), 256'(0));
    release2();

    // DEG=1, AW=16 instance: x^2 sum overflows 16 bits.
    set_frame(2);
    fx[0] = 8'd255; fx[1] = 8'd255;
    run_frame(1'b1, 4);
    chk("d1_sx2", 256'(if1.sx[47:32]), 256'(EXP1_SX2));
    chk("d1_sx1", 256'(if1.sx[31:16]), 256'(16'd510));
    chk("d1_ovf_set", 256'(if1.ovf), 256'(1));
    if1.out_ready = 1'b1;
    @(posedge clk); #1;
    if1.out_ready = 1'b0;
    chk("d1_idle_out_valid", 256'(if1.out_valid), 256'(0));

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
